// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding bus request, fetch-to-decode output register.
// Optional misaligned-pc check enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_ctrl #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] pc,
   input  logic        flush,
   input  logic        stall,
   output logic        ibus_valid,
   output logic [63:0] ibus_addr,
   input  logic        ibus_data_ok,
   input  logic [31:0] ibus_data,
   output logic        handshake_stall,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   output logic        inst_misalign
);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD, HOLD} state_t;

   state_t      state, state_nxt;
   logic [63:0] addr_q;
   logic        mis;
   logic        load, clear;
   logic [31:0] load_data;
   logic        load_mis;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign mis = (state == REQ) && (pc[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   always_comb begin
      state_nxt       = state;
      ibus_valid      = 1'b0;
      ibus_addr       = pc;
      handshake_stall = 1'b0;
      load            = 1'b0;
      load_data       = ibus_data;
      load_mis        = 1'b0;
      clear           = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = REQ;
            clear     = flush;
         end
         REQ: begin
            if (mis) begin
               // misaligned pc never reaches the bus; a NOP is injected instead
               if (flush) clear = 1'b1;
               else begin
                  load      = 1'b1;
                  load_data = NOP_INST;
                  load_mis  = 1'b1;
                  if (stall) state_nxt = HOLD;
               end
            end else begin
               ibus_valid      = 1'b1;
               handshake_stall = !ibus_data_ok;
               if (flush) begin
                  clear = 1'b1;
                  if (!ibus_data_ok) state_nxt = DISCARD;
               end else if (ibus_data_ok) begin
                  load = 1'b1;
                  if (stall) state_nxt = HOLD;
               end else if (!stall) begin
                  clear = 1'b1;
               end
            end
         end
         DISCARD: begin
            // finish the abandoned request on its original address, drop the data
            ibus_valid      = 1'b1;
            ibus_addr       = addr_q;
            handshake_stall = !ibus_data_ok;
            clear           = 1'b1;
            if (ibus_data_ok) state_nxt = REQ;
         end
         HOLD: begin
            if (flush || !stall) begin
               clear     = 1'b1;
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         addr_q        <= '0;
         inst_valid    <= 1'b0;
         inst          <= '0;
         inst_pc       <= '0;
         inst_misalign <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == REQ) addr_q <= pc;
         if (load) begin
            inst_valid    <= 1'b1;
            inst          <= load_data;
            inst_pc       <= pc;
            inst_misalign <= load_mis;
         end else if (clear) begin
            inst_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes expected captures, a negedge monitor pops and compares.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pc;
   logic        flush, stall;
   logic        ibus_valid;
   logic [63:0] ibus_addr;
   logic        ibus_data_ok;
   logic [31:0] ibus_data;
   logic        handshake_stall;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_misalign;

   typedef struct {
      logic [31:0] i;
      logic [63:0] p;
      logic        m;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   fetch_ctrl dut (
      .clk(clk), .reset(reset), .pc(pc), .flush(flush), .stall(stall),
      .ibus_valid(ibus_valid), .ibus_addr(ibus_addr), .ibus_data_ok(ibus_data_ok),
      .ibus_data(ibus_data), .handshake_stall(handshake_stall), .inst_valid(inst_valid),
      .inst(inst), .inst_pc(inst_pc), .inst_misalign(inst_misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // advance one cycle; inputs set afterwards apply to the new cycle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] i, input logic [63:0] p, input logic m);
      exp_t e;
      e.i = i; e.p = p; e.m = m;
      q.push_back(e);
   endtask

   // monitor: every newly captured instruction must match the head of the queue
   logic        prev_v = 1'b0;
   logic [31:0] prev_i = '0;
   logic [63:0] prev_p = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset && inst_valid && (!prev_v || inst != prev_i || inst_pc != prev_p)) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_inst: got inst %h pc %h with nothing expected", inst, inst_pc);
         end else begin
            e = q.pop_front();
            chk("mon_inst", {32'h0, inst}, {32'h0, e.i});
            chk("mon_pc", inst_pc, e.p);
            chk("mon_misalign", {63'h0, inst_misalign}, {63'h0, e.m});
         end
      end
      prev_v = inst_valid;
      prev_i = inst;
      prev_p = inst_pc;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; pc = 64'h8000_0000; flush = 0; stall = 0;
      ibus_data_ok = 0; ibus_data = '0;
      step(); step();
      #1;
      chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
      chk("rst_inst", {32'h0, inst}, 64'h0);
      chk("rst_inst_pc", inst_pc, 64'h0);
      chk("rst_misalign", {63'h0, inst_misalign}, 64'h0);
      chk("rst_ibus_valid", {63'h0, ibus_valid}, 64'h0);
      chk("rst_hs", {63'h0, handshake_stall}, 64'h0);

      // IDLE cycle after reset: stray data_ok ignored
      reset = 0; ibus_data_ok = 1; ibus_data = 32'hDEAD_BEEF;
      #1 chk("idle_ibus_valid", {63'h0, ibus_valid}, 64'h0);
      chk("idle_hs", {63'h0, handshake_stall}, 64'h0);
      step();

      // 3 wait cycles then response
      ibus_data_ok = 0;
      for (int w = 0; w < 3; w++) begin
         #1 chk("wait_ibus_valid", {63'h0, ibus_valid}, 64'h1);
         chk("wait_addr", ibus_addr, 64'h8000_0000);
         chk("wait_hs", {63'h0, handshake_stall}, 64'h1);
         step();
      end
      ibus_data_ok = 1; ibus_data = 32'h0000_0093;
      push(32'h0000_0093, 64'h8000_0000, 1'b0);
      #1 chk("resp_ibus_valid", {63'h0, ibus_valid}, 64'h1);
      chk("resp_addr", ibus_addr, 64'h8000_0000);
      chk("resp_hs", {63'h0, handshake_stall}, 64'h0);
      step();

      // zero-wait back-to-back fetches
      for (int i = 0; i < 3; i++) begin
         pc = 64'h8000_0000 + 64'(4 * i);
         ibus_data_ok = 1; ibus_data = 32'h0010_0093 + 32'(i << 7);
         push(ibus_data, pc, 1'b0);
         #1 chk("zw_hs", {63'h0, handshake_stall}, 64'h0);
         chk("zw_addr", ibus_addr, pc);
         step();
         #1 chk("zw_inst_valid", {63'h0, inst_valid}, 64'h1);
      end

      // flush during 2nd wait cycle -> DISCARD
      pc = 64'h8000_0004; ibus_data_ok = 0;
      step();
      flush = 1;
      #1 chk("fl_wait2_hs", {63'h0, handshake_stall}, 64'h1);
      step();
      #1 chk("disc_ibus_valid", {63'h0, ibus_valid}, 64'h1);
      chk("disc_addr", ibus_addr, 64'h8000_0004);
      chk("disc_hs", {63'h0, handshake_stall}, 64'h1);
      step();
      ibus_data_ok = 1; ibus_data = 32'h0BAD_0BAD;
      #1 chk("disc_ok_hs", {63'h0, handshake_stall}, 64'h0);
      step();
      flush = 0; ibus_data_ok = 0; pc = 64'h8000_0100;
      #1 chk("redir_addr", ibus_addr, 64'h8000_0100);
      chk("redir_ibus_valid", {63'h0, ibus_valid}, 64'h1);
      chk("redir_inst_valid", {63'h0, inst_valid}, 64'h0);
      step();
      ibus_data_ok = 1; ibus_data = 32'h1000_0093;
      push(32'h1000_0093, 64'h8000_0100, 1'b0);
      step();

      // capture 0x8000_0008 with stall, hold for 5 cycles
      pc = 64'h8000_0008; ibus_data = 32'h2000_0093; stall = 1;
      push(32'h2000_0093, 64'h8000_0008, 1'b0);
      step();
      ibus_data_ok = 0;
      for (int s = 0; s < 5; s++) begin
         #1 chk("hold_ibus_valid", {63'h0, ibus_valid}, 64'h0);
         chk("hold_inst_valid", {63'h0, inst_valid}, 64'h1);
         chk("hold_inst_pc", inst_pc, 64'h8000_0008);
         chk("hold_inst", {32'h0, inst}, 64'h2000_0093);
         if (s < 4) step();
      end
      stall = 0; pc = 64'h8000_000C;
      step();
      #1 chk("unstall_ibus_valid", {63'h0, ibus_valid}, 64'h1);
      chk("unstall_addr", ibus_addr, 64'h8000_000C);
      chk("unstall_inst_valid", {63'h0, inst_valid}, 64'h0);
      ibus_data_ok = 1; ibus_data = 32'h3000_0093;
      push(32'h3000_0093, 64'h8000_000C, 1'b0);
      step();

      // flush and data_ok together
      pc = 64'h8000_0010; flush = 1; ibus_data = 32'h0BAD_0002;
      #1 chk("flok_hs", {63'h0, handshake_stall}, 64'h0);
      step();
      flush = 0; ibus_data_ok = 0; pc = 64'h8000_0200;
      #1 chk("flok_inst_valid", {63'h0, inst_valid}, 64'h0);
      chk("flok_addr", ibus_addr, 64'h8000_0200);
      chk("flok_ibus_valid", {63'h0, ibus_valid}, 64'h1);
      ibus_data_ok = 1; ibus_data = 32'h4000_0093;
      push(32'h4000_0093, 64'h8000_0200, 1'b0);
      stall = 1;
      step();

      // flush while stalled in HOLD: flush wins
      ibus_data_ok = 0; flush = 1; pc = 64'h8000_0300;
      #1 chk("fs_ibus_valid", {63'h0, ibus_valid}, 64'h0);
      step();
      flush = 0; stall = 0;
      #1 chk("fs_inst_valid", {63'h0, inst_valid}, 64'h0);
      chk("fs_req", {63'h0, ibus_valid}, 64'h1);
      step();

      // misaligned pc
      pc = 64'h8000_0002;
`ifdef FETCH_MISALIGN_CHECK_EN
      ibus_data_ok = 0;
      #1 chk("mis_ibus_valid", {63'h0, ibus_valid}, 64'h0);
      chk("mis_hs", {63'h0, handshake_stall}, 64'h0);
      push(32'h0000_0013, 64'h8000_0002, 1'b1);
`else
      #1 chk("mis_addr", ibus_addr, 64'h8000_0002);
      chk("mis_ibus_valid", {63'h0, ibus_valid}, 64'h1);
      ibus_data_ok = 1; ibus_data = 32'h0000_0293;
      push(32'h0000_0293, 64'h8000_0002, 1'b0);
`endif
      step();

      // reset mid-transaction, then data_ok in the following cycle is ignored
      ibus_data_ok = 0; pc = 64'h8000_0400;
      step();
      reset = 1;
      step();
      reset = 0; ibus_data_ok = 1; ibus_data = 32'h0BAD_0003;
      #1 chk("rst2_ibus_valid", {63'h0, ibus_valid}, 64'h0);
      chk("rst2_hs", {63'h0, handshake_stall}, 64'h0);
      chk("rst2_inst_valid", {63'h0, inst_valid}, 64'h0);
      step();
      ibus_data_ok = 0;
      step();
      #1 chk("rst2_after_inst_valid", {63'h0, inst_valid}, 64'h0);
      step(); step();

      chk("queue_drained", 64'(q.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: NOP_INST, 32'h0000_0013, instruction word injected on a misaligned fetch.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc  input  64  current fetch address from the PC register.
REQ-005 flush  input  1  redirect from jump resolution; the source holds it and its target while handshake_stall=1.
REQ-006 stall  input  1  downstream (load-use) stall; holds the fetch output register.
REQ-007 ibus_valid  output  1  instruction-bus request valid.
REQ-008 ibus_addr  output  64  request address.
REQ-009 ibus_data_ok  input  1  response valid; zero-wait (same-cycle) responses are legal.
REQ-010 ibus_data  input  32  response instruction word.
REQ-011 handshake_stall  output  1  freezes the PC register while a bus transaction is unresolved.
REQ-012 inst_valid  output  1  fetch-to-decode register holds a valid instruction.
REQ-013 inst  output  32  fetched instruction.
REQ-014 inst_pc  output  64  address of inst.
REQ-015 inst_misalign  output  1  inst came from a misaligned pc.

Function
REQ-016 FSM states: IDLE, REQ, DISCARD, HOLD; reset state IDLE.
REQ-017 IDLE: ibus_valid=0, handshake_stall=0; unconditional transition to REQ next cycle.
REQ-018 REQ: ibus_valid=1, ibus_addr=pc (combinational; pc remains stable because handshake_stall holds it).
REQ-019 handshake_stall=1 in REQ when ibus_data_ok=0, and in DISCARD when ibus_data_ok=0; 0 in all other cases.
REQ-020 REQ with ibus_data_ok=1 and flush=0: next cycle inst<=ibus_data, inst_pc<=pc, inst_valid<=1, inst_misalign<=0.
REQ-021 In the REQ-020 case, the next state is HOLD if stall=1; otherwise it remains REQ, giving 1 instruction/cycle with a zero-wait bus.
REQ-022 REQ with flush=1 and ibus_data_ok=0: go to DISCARD; inst_valid<=0.
REQ-023 REQ with flush=1 and ibus_data_ok=1: data dropped, inst_valid<=0, stay REQ; the PC register takes the redirect this cycle.
REQ-024 DISCARD: ibus_valid=1 with the original address; on ibus_data_ok the data is dropped, inst_valid stays 0, and the next state is REQ.
REQ-025 HOLD: ibus_valid=0; inst/inst_pc/inst_valid held while stall=1; on stall=0 go to REQ and inst_valid<=0 unless a new response is captured.
REQ-026 flush in HOLD or IDLE: inst_valid<=0 next cycle, next state REQ.
REQ-027 Outside REQ/DISCARD, ibus_data_ok is ignored.
REQ-028 Simultaneous flush and stall: flush wins; the output is cleared.

Reset
REQ-029 Reset values: inst_valid=0, inst=0, inst_pc=0, inst_misalign=0, state=IDLE; therefore ibus_valid=0 and handshake_stall=0.
REQ-030 Reset asserted mid-transaction abandons it; any ibus_data_ok in the cycle after reset is ignored.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN.
REQ-032 Defined: in REQ with pc[1:0]!=0, ibus_valid=0 and handshake_stall=0; next cycle inst=NOP_INST, inst_pc=pc, inst_valid=1, inst_misalign=1.
REQ-033 Undefined: pc[1:0] is not checked; ibus_addr=pc; inst_misalign is tied 0.

Verification
REQ-034 Reset released, pc=0x8000_0000, bus returns 0x00000093 after 3 wait cycles -> ibus_valid high for 4 cycles with addr stable; handshake_stall=1 for 3 cycles; next cycle inst=0x00000093, inst_pc=0x8000_0000, inst_valid=1.
REQ-035 Zero-wait bus, pc stepping 0x8000_0000/4/8 -> inst_valid=1 on consecutive cycles; inst_pc matches in order; handshake_stall never asserted.
REQ-036 flush during the 2nd wait cycle of fetch 0x8000_0004 -> DISCARD; the returned word is not presented; handshake_stall drops on data_ok; the next request uses the redirect target 0x8000_0100.
REQ-037 stall=1 for 5 cycles after capturing 0x8000_0008 -> inst held; ibus_valid=0; on stall=0 the next request is issued.
REQ-038 flush and data_ok in the same cycle -> inst_valid=0 next cycle; the next request uses the target.
REQ-039 FETCH_MISALIGN_CHECK_EN defined, pc=0x8000_0002 -> no bus request; inst=0x00000013, inst_misalign=1; with the macro undefined, ibus_addr=0x8000_0002.
